bit_scan_counter: RTL and testbench
===================================

BIT_SCAN_COUNTER -- requirements
Module: bit_scan_counter

Interface
REQ-001 Parameter WIDTH, default 16, data width; SHALL be a multiple of STEP and at least 2.
REQ-002 Parameter STEP, default 2, bits processed per BUSY cycle; SHALL be 1, 2, 4 or 8.
REQ-003 Localparam OUT_W = $clog2(WIDTH+1), width of count.
REQ-004 Port: clk  input  1  sole clock, rising-edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  level request; sampled only in IDLE.
REQ-007 Port: mode  input  2  operation: 00 count ones, 01 count zeros, 10 leading zeros, 11 trailing zeros.
REQ-008 Port: in  input  WIDTH  operand; sampled only on the load edge.
REQ-009 Port: count  output  OUT_W  result, registered.
REQ-010 Port: done  output  1  result valid, registered.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-012 IDLE with start=1 SHALL load the working register A and go to BUSY on that edge; count SHALL clear to 0.
REQ-013 Load transform: mode 00 A=in; 01 A=~in; 10 A=bit-reversed in; 11 A=in.
REQ-014 Each BUSY cycle SHALL examine A[STEP-1:0], update count, and shift A right by STEP.
REQ-015 Popcount modes (00/01): count SHALL add the number of ones in the chunk; BUSY SHALL exit when post-shift A==0.
REQ-016 Zero-scan modes (10/11): if the chunk has no one, count SHALL add STEP; otherwise count SHALL add the index of the lowest set bit in the chunk and BUSY SHALL exit.
REQ-017 BUSY SHALL also exit after WIDTH/STEP cycles, whatever the mode.
REQ-018 The BUSY exit edge SHALL go to DONE; done SHALL be 1 exactly while in DONE; count SHALL be final and stable in DONE.
REQ-019 DONE SHALL hold while start=1 and SHALL return to IDLE on the first edge with start=0; done SHALL fall on that edge.
REQ-020 count SHALL retain its last value in IDLE until the next load.
REQ-021 Changes on start, mode or in during BUSY SHALL be ignored; the operation SHALL complete.
REQ-022 Latency from load edge to done=1 SHALL be 1 to WIDTH/STEP cycles.
REQ-023 count SHALL never exceed WIDTH; no wrap is permitted.

Reset
REQ-024 reset_n=0 SHALL, asynchronously and in any state, force state to IDLE, count to 0, done to 0 and A to 0.
REQ-025 Release SHALL take effect on the next rising clk; start high at release SHALL load on the first edge after release.

Configuration
REQ-026 Macro BIT_SCAN_CYCLE_COUNT_EN defined: extra output cycles [OUT_W-1:0] SHALL equal the number of BUSY cycles of the last operation, cleared on load and reset, valid in DONE.
REQ-027 Macro BIT_SCAN_CYCLE_COUNT_EN undefined: port cycles and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package bit_scan_pkg SHALL hold typedef enum scan_mode_t (MODE_ONES, MODE_ZEROS, MODE_LZ, MODE_TZ) and typedef enum scan_state_t (IDLE, BUSY, DONE).
REQ-029 Sub-module bit_scan_chunk SHALL be combinational, parametrised by STEP, and output ones_cnt, first_one_idx and any_one for one chunk.
REQ-030 All registers SHALL be in a single always_ff with asynchronous negedge reset_n.

Verification (WIDTH=16, STEP=2)
REQ-031 Mode 00, in=16'hD100, start held -> done rises 8 cycles after load with count=4.
REQ-032 Mode 01, in=16'hFFFF -> done after 1 BUSY cycle, count=0.
REQ-033 Mode 11, in=16'h0040 -> done after 4 BUSY cycles, count=6; mode 10, in=16'h0000 -> 8 cycles, count=16.
REQ-034 Mode 10, in=16'h0100 -> count=7; toggle start and in during BUSY -> result unaffected.
REQ-035 done=1 with start held 5 cycles -> done and count stable; start=0 -> IDLE next edge, done=0, count retained.
REQ-036 reset_n pulsed low mid-BUSY between clock edges -> count=0 and done=0 immediately; a new start gives correct results; with BIT_SCAN_CYCLE_COUNT_EN, the REQ-031 run gives cycles=8.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// ---------------------------------------------------------------------------
// bit_scan_pkg
// Shared types for the bit scan counter: operation modes and FSM states,
// plus a small helper that classifies a mode as a zero-scan.
// No ports (package).
// ---------------------------------------------------------------------------
package bit_scan_pkg;

  typedef enum logic [1:0] {
    MODE_ONES  = 2'b00,
    MODE_ZEROS = 2'b01,
    MODE_LZ    = 2'b10,
    MODE_TZ    = 2'b11
  } scan_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } scan_state_t;

  // Leading/trailing-zero modes stop at the first set bit; the other two
  // modes accumulate a population count.
  function automatic logic is_zero_scan(input scan_mode_t m);
    return (m == MODE_LZ) || (m == MODE_TZ);
  endfunction

endpackage

// File: rtl/bit_scan_chunk.sv
// ---------------------------------------------------------------------------
// bit_scan_chunk
// Combinational analysis of one STEP-bit chunk.
// Ports:
//   chunk         in   STEP    bits under examination (bit 0 scanned first)
//   ones_cnt      out  CNT_W   number of set bits in the chunk
//   first_one_idx out  IDX_W   index of the lowest set bit (0 if none)
//   any_one       out  1       chunk has at least one set bit
// ---------------------------------------------------------------------------
module bit_scan_chunk #(
  parameter  int STEP  = 2,
  localparam int CNT_W = $clog2(STEP + 1),
  localparam int IDX_W = (STEP > 1) ? $clog2(STEP) : 1
) (
  input  logic [STEP-1:0]  chunk,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [IDX_W-1:0] first_one_idx,
  output logic             any_one
);

  // Scanning from the top down lets the lowest set bit be the last writer
  // of first_one_idx.
  always_comb begin
    ones_cnt      = '0;
    first_one_idx = '0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        ones_cnt      = ones_cnt + CNT_W'(1);
        first_one_idx = IDX_W'(i);
      end
    end
  end

  assign any_one = |chunk;

endmodule

// File: rtl/bit_scan_counter.sv
// ---------------------------------------------------------------------------
// bit_scan_counter
// Multi-cycle bit counter: counts ones, zeros, leading zeros or trailing
// zeros of a WIDTH-bit operand, STEP bits per BUSY cycle.
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      level request, sampled in IDLE (and DONE to leave)
//   mode     in   2      00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros
//   in       in   WIDTH  operand, captured on the load edge
//   count    out  OUT_W  registered result
//   done     out  1      high exactly while in DONE
//   cycles   out  OUT_W  BUSY cycles of the last operation
//                        (only when BIT_SCAN_CYCLE_COUNT_EN is defined)
// ---------------------------------------------------------------------------
module bit_scan_counter
  import bit_scan_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 2,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] count,
  output logic             done
`ifdef BIT_SCAN_CYCLE_COUNT_EN
  ,
  output logic [OUT_W-1:0] cycles
`endif
);

  localparam int CNT_W  = $clog2(STEP + 1);
  localparam int IDX_W  = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int CHUNKS = WIDTH / STEP;

  scan_state_t      state_reg;
  scan_mode_t       mode_reg;
  logic [WIDTH-1:0] a_reg;
  logic [OUT_W-1:0] count_reg;
  logic [OUT_W-1:0] iter_reg;
  logic             done_reg;

  logic [WIDTH-1:0] in_rev;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] a_shift;
  logic [OUT_W-1:0] add_val;
  logic [OUT_W-1:0] count_next;
  logic             busy_exit;

  logic [CNT_W-1:0] ones_cnt;
  logic [IDX_W-1:0] first_one_idx;
  logic             any_one;

  // Bit reversal turns a leading-zero scan into a trailing-zero scan, so the
  // datapath only ever scans from bit 0 upward.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign in_rev[gi] = in[WIDTH-1-gi];
    end
  endgenerate

  always_comb begin
    a_load = in;
    case (scan_mode_t'(mode))
      MODE_ZEROS: a_load = ~in;
      MODE_LZ:    a_load = in_rev;
      default:    a_load = in;
    endcase
  end

  bit_scan_chunk #(.STEP(STEP)) u_chunk (
    .chunk         (a_reg[STEP-1:0]),
    .ones_cnt      (ones_cnt),
    .first_one_idx (first_one_idx),
    .any_one       (any_one)
  );

  assign a_shift = a_reg >> STEP;

  always_comb begin
    if (!is_zero_scan(mode_reg))
      add_val = OUT_W'(ones_cnt);
    else if (any_one)
      add_val = OUT_W'(first_one_idx);
    else
      add_val = OUT_W'(STEP);
  end

  assign count_next = count_reg + add_val;

  // Popcount finishes once nothing set remains; zero-scan finishes at the
  // first set bit. The chunk limit bounds both (and caps count at WIDTH).
  assign busy_exit = (iter_reg == OUT_W'(CHUNKS - 1)) ||
                     (is_zero_scan(mode_reg) ? any_one : (a_shift == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_ONES;
      a_reg     <= '0;
      count_reg <= '0;
      iter_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a_load;
            mode_reg  <= scan_mode_t'(mode);
            count_reg <= '0;
            iter_reg  <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          a_reg     <= a_shift;
          count_reg <= count_next;
          iter_reg  <= iter_reg + OUT_W'(1);
          if (busy_exit) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign done  = done_reg;

`ifdef BIT_SCAN_CYCLE_COUNT_EN
  assign cycles = iter_reg;
`endif

endmodule

// File: tb/tb_bit_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bit_scan_counter
// Self-checking bench for bit_scan_counter (WIDTH=16, STEP=2). A driver
// issues operations and queues the expected result; a monitor pops and
// compares whenever done rises.
// ---------------------------------------------------------------------------
module tb_bit_scan_counter;

  localparam int WIDTH  = 16;
  localparam int STEP   = 2;
  localparam int OUT_W  = $clog2(WIDTH + 1);
  localparam int CHUNKS = WIDTH / STEP;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [1:0]       mode    = 2'b00;
  logic [WIDTH-1:0] in_v    = '0;
  logic [OUT_W-1:0] count;
  logic             done;
`ifdef BIT_SCAN_CYCLE_COUNT_EN
  logic [OUT_W-1:0] cycles;
`endif

  bit_scan_counter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .in      (in_v),
    .count   (count),
    .done    (done)
`ifdef BIT_SCAN_CYCLE_COUNT_EN
    ,
    .cycles  (cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cnt;
    int               lat;
    int               load_cyc;
    int               m;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference result straight from the definition of each mode.
  function automatic int ref_count(input int m, input logic [WIDTH-1:0] v);
    int r;
    r = 0;
    case (m)
      0: r = $countones(v);
      1: r = $countones(~v);
      2: begin
        r = WIDTH;
        for (int i = 0; i < WIDTH; i++) if (v[i]) r = WIDTH - 1 - i;
      end
      default: begin
        r = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) r = i;
      end
    endcase
    return r;
  endfunction

  // Expected BUSY cycles: popcount runs until the chunk holding the highest
  // counted bit; zero scans run until the chunk holding the first one.
  function automatic int ref_lat(input int m, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] a;
    int h, c;
    if (m < 2) begin
      a = (m == 1) ? ~v : v;
      if (a == '0) return 1;
      h = 0;
      for (int i = 0; i < WIDTH; i++) if (a[i]) h = i;
      return h / STEP + 1;
    end
    c = ref_count(m, v);
    return (c == WIDTH) ? CHUNKS : c / STEP + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every rising done.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1, expected no pending op");
        end else begin
          e = sb_q.pop_front();
          check("count", int'(count), e.cnt);
          check("latency", cyc - e.load_cyc, e.lat);
`ifdef BIT_SCAN_CYCLE_COUNT_EN
          check("cycles", int'(cycles), e.lat);
`endif
          $display("op mode=%0d in=%h count=%0d exp=%0d lat=%0d exp=%0d",
                   e.m, e.val, count, e.cnt, cyc - e.load_cyc, e.lat);
        end
      end
      prev = done;
    end
  end

  // Issue one operation, scramble inputs during BUSY, hold in DONE for
  // 'hold' cycles, then release start and check the return to IDLE.
  task automatic run_op(input int m, input logic [WIDTH-1:0] v, input int hold,
                        input bit rel);
    exp_t e;
    int k;
    logic [OUT_W-1:0] held;
    @(negedge clk);
    mode  = m[1:0];
    in_v  = v;
    start = 1'b1;
    if (rel) reset_n = 1'b1;
    e.cnt      = ref_count(m, v);
    e.lat      = ref_lat(m, v);
    e.load_cyc = cyc + 1;
    e.m        = m;
    e.val      = v;
    sb_q.push_back(e);
    k = 0;
    @(negedge clk);
    while (!done && k < 40) begin
      start = 1'($urandom_range(0, 1));
      in_v  = WIDTH'($urandom);
      mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: done=0 after %0d cycles, expected 1", k);
      start = 1'b0;
      sb_q.delete();
    end else begin
      held  = count;
      start = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_v = WIDTH'($urandom);
        mode = 2'($urandom_range(0, 3));
        @(negedge clk);
        check("hold_done", int'(done), 1);
        check("hold_count", int'(count), int'(held));
      end
      start = 1'b0;
      @(negedge clk);
      check("idle_done", int'(done), 0);
      check("idle_count", int'(count), int'(held));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int m, sel, hold;
    logic [WIDTH-1:0] v;

    #12;
    check("rst_count", int'(count), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 16'hD100, 5, 1'b0);
    run_op(1, 16'hFFFF, 0, 1'b0);
    run_op(3, 16'h0040, 1, 1'b0);
    run_op(2, 16'h0000, 2, 1'b0);
    run_op(2, 16'h0100, 0, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    mode  = 2'b00;
    in_v  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_count", int'(count), 2);
    #1 reset_n = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_done", int'(done), 0);
    start = 1'b0;
    $display("op async reset mid-busy count=%0d done=%0d", count, done);
    @(negedge clk);
    check("arst_hold_done", int'(done), 0);
    // Release with start already high: loads on the first edge after release.
    run_op(3, 16'h0040, 0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      m   = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v = '0;
        1:       v = '1;
        2:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: v = WIDTH'($urandom);
      endcase
      hold = int'($urandom_range(0, 3));
      run_op(m, v, hold, 1'b0);
    end

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
